traffic_sequencer: RTL and testbench

- Phase controller for the two-road intersection: main road and country road.
- Sequences green, yellow and red for both roads.
- Generates the 5-bit countdown values (MainNumber, CountryNumber) and the blink flag C for the seven-segment display block.
- Adds a country-road vehicle-sensor extension and a night flashing-yellow mode.
- Sits between the 1 Hz / 2 Hz strobe divider and the display block.

---
 rtl/traffic_pkg.sv | 29 ++
 rtl/phase_timer.sv | 40 ++++
 rtl/traffic_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_traffic_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection phase controller: phase
// encoding, lamp codes and the display range limit.
package traffic_pkg;

  // Controller phases: main green/yellow, country green/yellow, night.
  typedef enum logic [2:0] {
    MG = 3'd0,
    MY = 3'd1,
    CG = 3'd2,
    CY = 3'd3,
    NT = 3'd4
  } phase_t;

  // Lamp codes, {R,Y,G} one-hot.
  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;

  // Largest value the seven-segment block can decode.
  localparam int DISP_MAX = 30;

  // Remaining-seconds sum at 6 bits, truncated to the 5-bit display width.
  function automatic logic [4:0] sum5(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[4:0];
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable 5-bit seconds down-counter. It stops at 1; the owner decides
// what to load when the phase ends (expire).
module phase_timer
  import traffic_pkg::*;
#(
  parameter logic [4:0] RESET_VAL = 5'd25
) (
  input  logic       CLK,
  input  logic       RET,
  input  logic       load,
  input  logic [4:0] load_val,
  input  logic       TICK,
  output logic [4:0] count,
  output logic [4:0] count_next,
  output logic       expire
);

  // Load has priority; otherwise count down on TICK but never below 1.
  // Loads beyond the display range are clamped so the digits stay decodable.
  always_comb begin
    count_next = count;
    if (load) begin
      count_next = (load_val > 5'(DISP_MAX)) ? 5'(DISP_MAX) : load_val;
    end else if (TICK && (count > 5'd1)) begin
      count_next = count - 5'd1;
    end
  end

  assign expire = TICK && (count == 5'd1);

  // Counter register.
  always_ff @(posedge CLK or posedge RET) begin
    if (RET) begin
      count <= RESET_VAL;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/traffic_sequencer.sv
// Two-road intersection phase controller. Sequences the main and country
// road lamps, produces the countdown digits and blink phase for the
// display block, extends main green until a country car is seen, and
// offers a night flashing-yellow mode.
module traffic_sequencer
  import traffic_pkg::*;
#(
  parameter int MAIN_GREEN  = 25,
  parameter int MAIN_YELLOW = 5,
  parameter int CTRY_GREEN  = 15,
  parameter int CTRY_YELLOW = 5
) (
  input  logic       CLK,
  input  logic       RET,
  input  logic       TICK,
  input  logic       HALF,
  input  logic       CAR,
  input  logic       NIGHT,
  output logic [4:0] MainNumber,
  output logic [4:0] CountryNumber,
  output logic       C,
  output logic [2:0] MainLight,
  output logic [2:0] CtryLight
);

  localparam logic [4:0] MG_LEN = 5'(MAIN_GREEN);
  localparam logic [4:0] MY_LEN = 5'(MAIN_YELLOW);
  localparam logic [4:0] CG_LEN = 5'(CTRY_GREEN);
  localparam logic [4:0] CY_LEN = 5'(CTRY_YELLOW);

  // Values shown while in reset: main green with its full time, country red.
  localparam logic [4:0] RST_MAIN = MG_LEN;
  localparam logic [4:0] RST_CTRY = sum5(MG_LEN, MY_LEN);

  phase_t     state_reg, state_next;
  logic       car_seen_reg, car_seen_next;
  logic       c_reg, c_next;

  logic       tick_run;
  logic       load;
  logic [4:0] load_val;
  logic [4:0] count;
  logic [4:0] count_next;
  logic       expire;

  logic [4:0] main_number_reg, main_number_next;
  logic [4:0] country_number_reg, country_number_next;
  logic [2:0] main_light_reg, main_light_next;
  logic [2:0] ctry_light_reg, ctry_light_next;

  // Seconds are frozen in night mode and whenever night is being requested,
  // so NIGHT always wins over a coincident TICK.
  assign tick_run = TICK && !NIGHT && (state_reg != NT);

  phase_timer #(
    .RESET_VAL (MG_LEN)
  ) u_timer (
    .CLK        (CLK),
    .RET        (RET),
    .load       (load),
    .load_val   (load_val),
    .TICK       (tick_run),
    .count      (count),
    .count_next (count_next),
    .expire     (expire)
  );

  // Next phase, timer reload, car memory and blink phase.
  always_comb begin
    state_next    = state_reg;
    load          = 1'b0;
    load_val      = MG_LEN;
    car_seen_next = car_seen_reg;
    c_next        = c_reg;

    if (NIGHT) begin
      state_next = NT;
    end else begin
      case (state_reg)
        MG: begin
          if (expire) begin
            load = 1'b1;
            if (car_seen_reg || CAR) begin
              state_next = MY;
              load_val   = MY_LEN;
            end else begin
              // No waiting car: grant main road another full green.
              load_val = MG_LEN;
            end
          end
        end
        MY: begin
          if (expire) begin
            state_next = CG;
            load       = 1'b1;
            load_val   = CG_LEN;
          end
        end
        CG: begin
          if (expire) begin
            state_next = CY;
            load       = 1'b1;
            load_val   = CY_LEN;
          end
        end
        CY: begin
          if (expire) begin
            state_next = MG;
            load       = 1'b1;
            load_val   = MG_LEN;
          end
        end
        NT: begin
          state_next = MG;
          load       = 1'b1;
          load_val   = MG_LEN;
        end
        default: begin
          state_next = MG;
          load       = 1'b1;
          load_val   = MG_LEN;
        end
      endcase
    end

    // A car is remembered while main has right of way; it is consumed when
    // the country road gets green, and forgotten when night mode ends.
    if (((state_reg == MG) || (state_reg == MY)) && CAR) begin
      car_seen_next = 1'b1;
    end
    if ((state_next == CG) && (state_reg != CG)) begin
      car_seen_next = 1'b0;
    end
    if ((state_reg == NT) && (state_next != NT)) begin
      car_seen_next = 1'b0;
    end

    // Blink phase starts "on" in every new phase; only the yellow and
    // night phases blink.
    if (state_next != state_reg) begin
      c_next = 1'b1;
    end else if ((state_reg == MY) || (state_reg == CY) || (state_reg == NT)) begin
      if (HALF) begin
        c_next = !c_reg;
      end
    end else begin
      c_next = 1'b1;
    end
  end

  // Display digits and lamps decoded from the phase and time being entered.
  always_comb begin
    main_number_next    = count_next;
    country_number_next = count_next;
    main_light_next     = L_RED;
    ctry_light_next     = L_RED;
    case (state_next)
      MG: begin
        country_number_next = sum5(count_next, MY_LEN);
        main_light_next     = L_GRN;
      end
      MY: begin
        main_light_next = L_YEL;
      end
      CG: begin
        main_number_next = sum5(count_next, CY_LEN);
        ctry_light_next  = L_GRN;
      end
      CY: begin
        ctry_light_next = L_YEL;
      end
      NT: begin
        main_number_next    = 5'd0;
        country_number_next = 5'd0;
        main_light_next     = L_YEL;
        ctry_light_next     = L_YEL;
      end
      default: begin
        main_light_next = L_RED;
      end
    endcase
  end

  // Phase, car memory, blink and registered outputs.
  always_ff @(posedge CLK or posedge RET) begin
    if (RET) begin
      state_reg          <= MG;
      car_seen_reg       <= 1'b0;
      c_reg              <= 1'b1;
      main_number_reg    <= RST_MAIN;
      country_number_reg <= RST_CTRY;
      main_light_reg     <= L_GRN;
      ctry_light_reg     <= L_RED;
    end else begin
      state_reg          <= state_next;
      car_seen_reg       <= car_seen_next;
      c_reg              <= c_next;
      main_number_reg    <= main_number_next;
      country_number_reg <= country_number_next;
      main_light_reg     <= main_light_next;
      ctry_light_reg     <= ctry_light_next;
    end
  end

  assign MainNumber    = main_number_reg;
  assign CountryNumber = country_number_reg;
  assign C             = c_reg;
  assign MainLight     = main_light_reg;
  assign CtryLight     = ctry_light_reg;

endmodule

// File: tb/tb_traffic_sequencer.sv
// Bench for traffic_sequencer: directed scenarios plus random traffic,
// all cycles checked by a scoreboard fed from a phase-level model.
module tb_traffic_sequencer;

  localparam int MAIN_GREEN  = 25;
  localparam int MAIN_YELLOW = 5;
  localparam int CTRY_GREEN  = 15;
  localparam int CTRY_YELLOW = 5;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  logic       CLK = 1'b0;
  logic       RET = 1'b1;
  logic       TICK = 1'b0;
  logic       HALF = 1'b0;
  logic       CAR = 1'b0;
  logic       NIGHT = 1'b0;
  logic [4:0] MainNumber;
  logic [4:0] CountryNumber;
  logic       C;
  logic [2:0] MainLight;
  logic [2:0] CtryLight;

  traffic_sequencer #(
    .MAIN_GREEN  (MAIN_GREEN),
    .MAIN_YELLOW (MAIN_YELLOW),
    .CTRY_GREEN  (CTRY_GREEN),
    .CTRY_YELLOW (CTRY_YELLOW)
  ) dut (
    .CLK           (CLK),
    .RET           (RET),
    .TICK          (TICK),
    .HALF          (HALF),
    .CAR           (CAR),
    .NIGHT         (NIGHT),
    .MainNumber    (MainNumber),
    .CountryNumber (CountryNumber),
    .C             (C),
    .MainLight     (MainLight),
    .CtryLight     (CtryLight)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [4:0] mn;
    logic [4:0] cn;
    logic       c;
    logic [2:0] ml;
    logic [2:0] cl;
  } obs_t;

  obs_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: phase name index (0 main green, 1 main yellow,
  // 2 country green, 3 country yellow, 4 night), seconds left, car memory,
  // blink phase.
  int m_phase;
  int m_rem;
  bit m_car;
  bit m_c;

  function automatic int phase_len(input int p);
    case (p)
      0: return MAIN_GREEN;
      1: return MAIN_YELLOW;
      2: return CTRY_GREEN;
      default: return CTRY_YELLOW;
    endcase
  endfunction

  function automatic void model_reset();
    m_phase = 0;
    m_rem   = MAIN_GREEN;
    m_car   = 1'b0;
    m_c     = 1'b1;
  endfunction

  function automatic void model_step(input bit t, input bit h, input bit car, input bit n);
    int old;
    old = m_phase;
    if ((m_phase <= 1) && car) m_car = 1'b1;
    if (n) begin
      m_phase = 4;
    end else if (m_phase == 4) begin
      m_phase = 0;
      m_rem   = MAIN_GREEN;
      m_car   = 1'b0;
    end else if (t) begin
      if (m_rem > 1) begin
        m_rem = m_rem - 1;
      end else if ((m_phase == 0) && !m_car) begin
        m_rem = MAIN_GREEN;
      end else begin
        m_phase = (m_phase + 1) % 4;
        m_rem   = phase_len(m_phase);
        if (m_phase == 2) m_car = 1'b0;
      end
    end
    if (m_phase != old) m_c = 1'b1;
    else if (h && (m_phase == 1 || m_phase == 3 || m_phase == 4)) m_c = ~m_c;
  endfunction

  function automatic obs_t model_expect();
    obs_t o;
    o.c = m_c;
    case (m_phase)
      0: begin o.mn = 5'(m_rem); o.cn = 5'(m_rem + MAIN_YELLOW); o.ml = GRN; o.cl = RED; end
      1: begin o.mn = 5'(m_rem); o.cn = 5'(m_rem); o.ml = YEL; o.cl = RED; end
      2: begin o.mn = 5'(m_rem + CTRY_YELLOW); o.cn = 5'(m_rem); o.ml = RED; o.cl = GRN; end
      3: begin o.mn = 5'(m_rem); o.cn = 5'(m_rem); o.ml = RED; o.cl = YEL; end
      default: begin o.mn = 5'd0; o.cn = 5'd0; o.ml = YEL; o.cl = YEL; end
    endcase
    return o;
  endfunction

  // Monitor: after each active edge, compare DUT outputs with the oldest
  // pending expectation.
  initial begin
    obs_t e;
    obs_t got;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = '{mn: MainNumber, cn: CountryNumber, c: C, ml: MainLight, cl: CtryLight};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL scoreboard t=%0t: got main=%0d ctry=%0d C=%b ml=%b cl=%b, want main=%0d ctry=%0d C=%b ml=%b cl=%b",
                   $time, got.mn, got.cn, got.c, got.ml, got.cl, e.mn, e.cn, e.c, e.ml, e.cl);
        end
      end
    end
  end

  // One clock of stimulus; the model predicts the state after this edge.
  task automatic cycle(input bit t, input bit h, input bit car, input bit n);
    @(negedge CLK);
    TICK  = t;
    HALF  = h;
    CAR   = car;
    NIGHT = n;
    model_step(t, h, car, n);
    exp_q.push_back(model_expect());
  endtask

  // One second: a TICK cycle followed by an idle cycle.
  task automatic sec(input bit car, input bit n);
    cycle(1'b1, 1'b0, car, n);
    cycle(1'b0, 1'b0, car, n);
  endtask

  task automatic settle();
    @(posedge CLK);
    #2;
  endtask

  task automatic spot(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  initial begin
    int guard;
    bit r_car;
    bit r_night;

    // Reset values while RET is held.
    model_reset();
    repeat (2) @(posedge CLK);
    #2;
    spot("reset MainNumber", MainNumber, 25);
    spot("reset CountryNumber", CountryNumber, 30);
    spot("reset C", C, 1);
    spot("reset MainLight", MainLight, GRN);
    spot("reset CtryLight", CtryLight, RED);
    @(negedge CLK);
    RET = 1'b0;
    $display("released reset");

    // 24 seconds, no car.
    repeat (24) sec(1'b0, 1'b0);
    settle();
    spot("24 ticks MainNumber", MainNumber, 1);
    spot("24 ticks CountryNumber", CountryNumber, 6);

    // Car coincident with the phase-ending tick.
    sec(1'b1, 1'b0);
    settle();
    spot("MY MainNumber", MainNumber, 5);
    spot("MY CountryNumber", CountryNumber, 5);
    spot("MY MainLight", MainLight, YEL);
    spot("MY entry C", C, 1);
    cycle(1'b0, 1'b1, 1'b1, 1'b0); settle(); spot("MY blink 1", C, 0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0); settle(); spot("MY blink 2", C, 1);
    cycle(1'b0, 1'b1, 1'b1, 1'b0); settle(); spot("MY blink 3", C, 0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0); settle(); spot("MY blink 4", C, 1);
    $display("main yellow with blink done");

    // Rest of the cycle.
    repeat (5) sec(1'b1, 1'b0);
    settle();
    spot("CG CountryNumber", CountryNumber, 15);
    spot("CG MainNumber", MainNumber, 20);
    spot("CG MainLight", MainLight, RED);
    spot("CG CtryLight", CtryLight, GRN);
    repeat (20) sec(1'b0, 1'b0);
    settle();
    spot("back MG MainNumber", MainNumber, 25);
    spot("back MG CountryNumber", CountryNumber, 30);
    spot("back MG MainLight", MainLight, GRN);
    $display("full cycle done");

    // No car: green extends.
    repeat (25) sec(1'b0, 1'b0);
    settle();
    spot("extend MainNumber", MainNumber, 25);
    spot("extend CountryNumber", CountryNumber, 30);
    spot("extend MainLight", MainLight, GRN);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (25) sec(1'b0, 1'b0);
    settle();
    spot("car pulse MainLight", MainLight, YEL);
    spot("car pulse MainNumber", MainNumber, 5);
    $display("extension and remembered car done");

    // Night during country green with coincident tick.
    repeat (5) sec(1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    settle();
    spot("NT MainLight", MainLight, YEL);
    spot("NT CtryLight", CtryLight, YEL);
    spot("NT MainNumber", MainNumber, 0);
    spot("NT CountryNumber", CountryNumber, 0);
    spot("NT entry C", C, 1);
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    settle();
    spot("NT blink", C, 0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    settle();
    spot("NT exit MainNumber", MainNumber, 25);
    spot("NT exit CountryNumber", CountryNumber, 30);
    spot("NT exit C", C, 1);
    spot("NT exit MainLight", MainLight, GRN);
    $display("night mode done");

    // Random traffic.
    r_car   = 1'b0;
    r_night = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) r_car = ~r_car;
      if ($urandom_range(0, 199) == 0) r_night = ~r_night;
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, r_car, r_night);
    end
    $display("random traffic done");

    // Reach country yellow, then pulse reset between edges.
    guard = 0;
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    while (m_phase != 3 && guard < 400) begin
      sec(1'b1, 1'b0);
      guard++;
    end
    spot("reach CY within bound", (m_phase == 3) ? 1 : 0, 1);
    sec(1'b0, 1'b0);
    @(negedge CLK);
    #1;
    spot("pre-reset CtryLight", CtryLight, YEL);
    TICK  = 1'b0;
    HALF  = 1'b0;
    CAR   = 1'b0;
    NIGHT = 1'b0;
    RET   = 1'b1;
    #1;
    spot("async reset MainNumber", MainNumber, 25);
    spot("async reset CountryNumber", CountryNumber, 30);
    spot("async reset C", C, 1);
    spot("async reset MainLight", MainLight, GRN);
    spot("async reset CtryLight", CtryLight, RED);
    RET = 1'b0;
    #1;
    model_reset();
    model_step(1'b0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(model_expect());
    repeat (30) sec(1'b0, 1'b0);
    settle();
    spot("post-reset pending expectations", exp_q.size(), 0);
    $display("async reset mid country yellow done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
